cdc_toggle_event_rx: RTL and testbench

Destination-domain event receiver placed directly downstream of the single-bit synchronizer. It consumes the synchronized copy of a source-domain toggle signal and turns each toggle into one event. Events are buffered in a pending counter and presented on a valid/ready interface, so no event is lost while the consumer stalls. An overflow condition is flagged with a sticky error bit.

---
 rtl/cdc_toggle_event_rx.sv | 126 ++++++++++++
 tb/tb_cdc_toggle_event_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cdc_toggle_event_rx.sv
// Destination-domain receiver for a synchronized toggle: each level change becomes
// one event, buffered in a saturating pending counter behind a valid/ready port.
module cdc_toggle_event_rx #(
   parameter int PENDING_W  = 4,
   parameter int ARM_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 s_rst,
   input  logic                 sync_toggle_in,
   output logic                 edge_pls,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [PENDING_W-1:0] pending_cnt,
   output logic                 ovf_sticky,
   input  logic                 ovf_clr
);

   typedef enum logic [0:0] {ST_ARM = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [PENDING_W-1:0] CNT_MAX  = '1;
   localparam logic [PENDING_W-1:0] CNT_ONE  = PENDING_W'(1);
   localparam logic [7:0]           ARM_LAST = 8'(ARM_CYCLES - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [7:0]           r_arm_cnt;
   logic                 r_toggle_q;
   logic                 r_edge_pls;
   logic                 r_ovf;
   logic [PENDING_W-1:0] r_cnt;
   logic                 w_arm_done;
   logic                 w_edge;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;

   assign w_arm_done = (r_arm_cnt == ARM_LAST);
   assign w_edge     = sync_toggle_in ^ r_toggle_q;
   assign w_pop      = out_vld & out_rdy;
   assign w_full     = (r_cnt == CNT_MAX);

   // State register
   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_state <= ST_ARM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: ARM runs for ARM_CYCLES cycles, RUN is left only by reset
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ARM:  w_state_nxt = w_arm_done ? ST_RUN : ST_ARM;
         ST_RUN:  w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_ARM;
      endcase
   end

   // Output logic: edges only become events once the reference level is established
   always_comb begin
      w_push = 1'b0;
      case (r_state)
         ST_RUN:  w_push = w_edge;
         default: w_push = 1'b0;
      endcase
   end

   // Arm-phase cycle counter
   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_arm_cnt <= 8'd0;
      end else if (r_state == ST_ARM && !w_arm_done) begin
         r_arm_cnt <= r_arm_cnt + 8'd1;
      end else begin
         r_arm_cnt <= r_arm_cnt;
      end
   end

   // Reference level tracks the input in every state, so the level at reset release is never an event
   always_ff @(posedge clk) begin
      r_toggle_q <= sync_toggle_in;
   end

   // Registered edge pulse
   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_edge_pls <= 1'b0;
      end else begin
         r_edge_pls <= w_push;
      end
   end

   // Pending counter: simultaneous push and pop cancel, even when full
   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_cnt <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_cnt <= w_full ? r_cnt : r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_ovf <= 1'b0;
      end else if (w_push && !w_pop && w_full) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= r_ovf;
      end
   end

   assign edge_pls    = r_edge_pls;
   assign pending_cnt = r_cnt;
   assign out_vld     = (r_cnt != '0);
   assign ovf_sticky  = r_ovf;

endmodule

// File: tb/tb_cdc_toggle_event_rx.sv
// Scoreboard bench: stimulus queues the cycle of each expected edge pulse and handshake,
// negedge monitors pop and compare; direct checks cover counter and overflow values.
module tb_cdc_toggle_event_rx;

   logic       clk = 1'b0;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   int         r;

   logic       rst4, tg4, rdy4, clr4, edge4, vld4, ovf4;
   logic [3:0] cnt4;
   logic       rst2, tg2, rdy2, clr2, edge2, vld2, ovf2;
   logic [1:0] cnt2;

   int q_e4[$];
   int q_h4[$];
   int q_e2[$];
   int q_h2[$];

   cdc_toggle_event_rx #(.PENDING_W(4), .ARM_CYCLES(3)) u4 (
      .clk(clk), .s_rst(rst4), .sync_toggle_in(tg4), .edge_pls(edge4), .out_vld(vld4),
      .out_rdy(rdy4), .pending_cnt(cnt4), .ovf_sticky(ovf4), .ovf_clr(clr4));

   cdc_toggle_event_rx #(.PENDING_W(2), .ARM_CYCLES(1)) u2 (
      .clk(clk), .s_rst(rst2), .sync_toggle_in(tg2), .edge_pls(edge2), .out_vld(vld2),
      .out_rdy(rdy2), .pending_cnt(cnt2), .ovf_sticky(ovf2), .ovf_clr(clr2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tog4();
      tg4 = ~tg4;
      q_e4.push_back(cyc + 1);
      if (rdy4) q_h4.push_back(cyc + 1);
   endtask

   task automatic tog2();
      tg2 = ~tg2;
      q_e2.push_back(cyc + 1);
   endtask

   // Monitors: every edge pulse and every handshake must match a queued expectation
   always @(negedge clk) begin
      if (edge4) begin
         if (q_e4.size() == 0) chk("edge4_unexpected", cyc, -1);
         else chk("edge4_cycle", cyc, q_e4.pop_front());
      end
      if (vld4 && rdy4) begin
         if (q_h4.size() == 0) chk("hs4_unexpected", cyc, -1);
         else chk("hs4_cycle", cyc, q_h4.pop_front());
      end
      if (edge2) begin
         if (q_e2.size() == 0) chk("edge2_unexpected", cyc, -1);
         else chk("edge2_cycle", cyc, q_e2.pop_front());
      end
      if (vld2 && rdy2) begin
         if (q_h2.size() == 0) chk("hs2_unexpected", cyc, -1);
         else chk("hs2_cycle", cyc, q_h2.pop_front());
      end
   end

   initial begin
      rst4 = 1'b1; tg4 = 1'b0; rdy4 = 1'b0; clr4 = 1'b0;
      rst2 = 1'b1; tg2 = 1'b0; rdy2 = 1'b0; clr2 = 1'b0;
      tick(3);
      chk("rst_cnt4", int'(cnt4), 0);
      chk("rst_vld4", int'(vld4), 0);
      chk("rst_ovf4", int'(ovf4), 0);
      tg4 = 1'b1;
      tick(1);
      rst4 = 1'b0; r = cyc;
      // ARM lasts cycles r..r+2; level changes there are reference updates only
      tick(1); tg4 = 1'b0;
      tick(1); tg4 = 1'b1;
      tick(1);
      chk("arm_cnt4", int'(cnt4), 0);
      chk("arm_vld4", int'(vld4), 0);
      tog4();
      tick(1);
      chk("first_vld4", int'(vld4), 1);
      chk("first_cnt4", int'(cnt4), 1);
      tick(3); tog4();
      tick(4); tog4();
      tick(1);
      chk("three_cnt4", int'(cnt4), 3);
      // Drain the three stalled events
      rdy4 = 1'b1;
      q_h4.push_back(cyc); q_h4.push_back(cyc + 1); q_h4.push_back(cyc + 2);
      tick(3);
      chk("drain_cnt4", int'(cnt4), 0);
      chk("drain_vld4", int'(vld4), 0);
      // Five toggles with the consumer always ready, last two back-to-back
      for (int i = 0; i < 3; i++) begin
         tog4(); tick(1);
         chk("rdy_peak_cnt4", int'(cnt4), 1);
         tick(2);
      end
      tog4(); tick(1);
      chk("b2b_cnt4_a", int'(cnt4), 1);
      tog4(); tick(1);
      chk("b2b_cnt4_b", int'(cnt4), 1);
      tick(1);
      chk("b2b_cnt4_end", int'(cnt4), 0);
      tick(3);
      chk("no_underflow_cnt4", int'(cnt4), 0);
      chk("no_ovf4", int'(ovf4), 0);
      rdy4 = 1'b0;

      // Narrow counter: capacity 3
      tg2 = 1'b1;
      tick(1);
      rst2 = 1'b0; r = cyc;
      tick(1);
      chk("arm_cnt2", int'(cnt2), 0);
      for (int i = 0; i < 3; i++) begin
         tog2(); tick(1);
      end
      chk("full_cnt2", int'(cnt2), 3);
      chk("pre_ovf2", int'(ovf2), 0);
      tog2(); tick(1);
      chk("ovf_cnt2", int'(cnt2), 3);
      chk("ovf_set2", int'(ovf2), 1);
      tick(1);
      clr2 = 1'b1; tog2();
      tick(1);
      clr2 = 1'b0;
      chk("set_wins_ovf2", int'(ovf2), 1);
      chk("set_wins_cnt2", int'(cnt2), 3);
      tick(1);
      clr2 = 1'b1;
      tick(1);
      clr2 = 1'b0;
      chk("clr_ovf2", int'(ovf2), 0);
      tick(1);
      // Push and pop together while full: no change, no overflow
      rdy2 = 1'b1; q_h2.push_back(cyc); tog2();
      tick(1);
      rdy2 = 1'b0;
      chk("pushpop_cnt2", int'(cnt2), 3);
      chk("pushpop_ovf2", int'(ovf2), 0);
      tog2();
      tick(1);
      chk("reovf2", int'(ovf2), 1);
      rdy2 = 1'b1; q_h2.push_back(cyc);
      tick(1);
      rdy2 = 1'b0;
      chk("pre_rst_cnt2", int'(cnt2), 2);
      // Reset mid-operation with the input moving through reset and ARM
      rst2 = 1'b1; tg2 = ~tg2;
      tick(1);
      rst2 = 1'b0; tg2 = ~tg2;
      chk("midrst_cnt2", int'(cnt2), 0);
      chk("midrst_vld2", int'(vld2), 0);
      chk("midrst_ovf2", int'(ovf2), 0);
      tick(1);
      chk("rearm_cnt2", int'(cnt2), 0);
      tog2();
      tick(1);
      chk("after_rearm_cnt2", int'(cnt2), 1);
      tick(4);
      chk("left_e4", q_e4.size(), 0);
      chk("left_h4", q_h4.size(), 0);
      chk("left_e2", q_e2.size(), 0);
      chk("left_h2", q_h2.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
